// File: rtl/noc_pkg.sv
// Shared sizes and types for the round-robin NoC aggregation hub.
package noc_pkg;
   localparam int CPU_NB_DEF = 4;
   localparam int DATA_W_DEF = 64;
   localparam int SRC_W_DEF  = $clog2(CPU_NB_DEF);
   localparam int CNT_W      = 32;

   typedef struct packed {
      logic [SRC_W_DEF-1:0]  src;
      logic [DATA_W_DEF-1:0] data;
   } noc_entry_t;
endpackage

// File: rtl/noc_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// pointer moves past the winner only when the hub reports an actual transfer.
module noc_rr_arbiter
   import noc_pkg::*;
#(
   parameter int N = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         req,
   input  logic                 advance,
   input  logic [$clog2(N)-1:0] adv_idx,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] grant_idx
);
   localparam int IW = $clog2(N);

   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW-1:0] scan_idx;
   logic          found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      scan_idx  = ptr_q;
      for (int k = 0; k < N; k++) begin
         if (!found && req[scan_idx]) begin
            found           = 1'b1;
            grant[scan_idx] = 1'b1;
            grant_idx       = scan_idx;
         end
         scan_idx = (scan_idx == IW'(N-1)) ? '0 : scan_idx + 1'b1;
      end
   end

   // Pointer holds whenever nothing transfers, including a grant blocked by a full FIFO.
   always_comb begin
      ptr_d = ptr_q;
      if (advance)
         ptr_d = (adv_idx == IW'(N-1)) ? '0 : adv_idx + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end
endmodule

// File: rtl/noc_rr_hub.sv
// NoC hub: round-robin accepts one CPU word per cycle into a small FIFO tagged
// with its source index, drains it through one output port, counts per-CPU accepts.
module noc_rr_hub
   import noc_pkg::*;
#(
   parameter int CPU_NB     = 4,
   parameter int DATA_W     = 64,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      data_vld   [CPU_NB],
   input  logic [DATA_W-1:0]         data       [CPU_NB],
   output logic                      data_rdy   [CPU_NB],
   output logic                      out_vld,
   input  logic                      out_rdy,
   output logic [DATA_W-1:0]         out_data,
   output logic [$clog2(CPU_NB)-1:0] out_src,
   output logic [CNT_W-1:0]          accept_cnt [CPU_NB]
);
   localparam int SW = $clog2(CPU_NB);
   localparam int AW = $clog2(FIFO_DEPTH);

   // A word moves on either side only when valid and ready are both high at the
   // rising edge; ready may depend on valid, valid must never depend on ready.

   logic [CPU_NB-1:0] req;
   logic [CPU_NB-1:0] grant;
   logic [SW-1:0]     grant_idx;
   logic              full, empty, push, pop;

   logic [DATA_W-1:0] mem_data_q [FIFO_DEPTH];
   logic [SW-1:0]     mem_src_q  [FIFO_DEPTH];
   logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0]  acc_q [CPU_NB];

   always_comb begin
      for (int i = 0; i < CPU_NB; i++) req[i] = data_vld[i];
   end

   noc_rr_arbiter #(.N(CPU_NB)) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .advance   (push),
      .adv_idx   (grant_idx),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
   assign empty = (cnt_q == '0);
   assign push  = (|grant) && !full && rst_n;
   assign pop   = !empty && out_rdy;

   always_comb begin
      for (int i = 0; i < CPU_NB; i++) data_rdy[i] = grant[i] && !full && rst_n;
   end

   always_comb begin
      wr_d  = push ? wr_q + 1'b1 : wr_q;
      rd_d  = pop  ? rd_q + 1'b1 : rd_q;
      cnt_d = cnt_q;
      if (push && !pop)      cnt_d = cnt_q + 1'b1;
      else if (!push && pop) cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         for (int i = 0; i < CPU_NB; i++) acc_q[i] <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
         if (push) acc_q[grant_idx] <= acc_q[grant_idx] + 1'b1;
      end
   end

   // Storage needs no reset: the occupancy count alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_data_q[wr_q] <= data[grant_idx];
         mem_src_q[wr_q]  <= grant_idx;
      end
   end

   assign out_vld  = !empty;
   assign out_data = empty ? '0 : mem_data_q[rd_q];
   assign out_src  = empty ? '0 : mem_src_q[rd_q];

   always_comb begin
      for (int i = 0; i < CPU_NB; i++) accept_cnt[i] = acc_q[i];
   end
endmodule

// File: tb/tb_noc_rr_hub.sv
// Directed bench for noc_rr_hub: reset, single word, contention, fairness,
// backpressure and mid-stream reset with hand-computed expectations.
module tb_noc_rr_hub;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        data_vld   [4];
   logic [63:0] data       [4];
   logic        data_rdy   [4];
   logic        out_vld;
   logic        out_rdy;
   logic [63:0] out_data;
   logic [1:0]  out_src;
   logic [31:0] accept_cnt [4];
   logic [3:0]  rdy_vec;

   int n_checks = 0;
   int n_fail   = 0;

   noc_rr_hub dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .data_vld   (data_vld),
      .data       (data),
      .data_rdy   (data_rdy),
      .out_vld    (out_vld),
      .out_rdy    (out_rdy),
      .out_data   (out_data),
      .out_src    (out_src),
      .accept_cnt (accept_cnt)
   );

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < 4; i++) rdy_vec[i] = data_rdy[i];
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin data_vld[i] = 1'b0; data[i] = '0; end
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      out_rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin data_vld[i] = 1'b1; data[i] = 64'(i + 1); end
      for (int c = 0; c < 3; c++) begin
         #1;
         n_checks++; if (rdy_vec !== 4'b0000) begin n_fail++; $display("FAIL reset_rdy c=%0d got %b exp 0000", c, rdy_vec); end
         n_checks++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL reset_out_vld c=%0d got %b exp 0", c, out_vld); end
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (accept_cnt[i] !== 32'd0) begin n_fail++; $display("FAIL reset_cnt[%0d] got %0d exp 0", i, accept_cnt[i]); end
      end
      for (int i = 0; i < 4; i++) data_vld[i] = 1'b0;
      rst_n = 1'b1;
      tick();
      n_checks++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL reset_release_vld got %b exp 0", out_vld); end
   endtask

   task automatic test_single();
      do_reset();
      out_rdy     = 1'b1;
      data[2]     = 64'h1234;
      data_vld[2] = 1'b1;
      #1;
      n_checks++; if (rdy_vec !== 4'b0100) begin n_fail++; $display("FAIL single_rdy got %b exp 0100", rdy_vec); end
      tick();
      data_vld[2] = 1'b0;
      #1;
      n_checks++; if (out_vld !== 1'b1) begin n_fail++; $display("FAIL single_out_vld got %b exp 1", out_vld); end
      n_checks++; if (out_data !== 64'h1234) begin n_fail++; $display("FAIL single_out_data got %h exp 1234", out_data); end
      n_checks++; if (out_src !== 2'd2) begin n_fail++; $display("FAIL single_out_src got %0d exp 2", out_src); end
      n_checks++; if (accept_cnt[2] !== 32'd1) begin n_fail++; $display("FAIL single_cnt2 got %0d exp 1", accept_cnt[2]); end
      tick();
      n_checks++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL single_drained got %b exp 0", out_vld); end
   endtask

   task automatic test_contention();
      logic [63:0] base;
      logic [3:0]  exp_rdy;
      base = 64'hA0A0_0000_0000_00A0;
      do_reset();
      out_rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin data[i] = base + 64'(i); data_vld[i] = 1'b1; end
      for (int c = 0; c < 5; c++) begin
         #1;
         exp_rdy = (c < 4) ? (4'b0001 << c) : 4'b0000;
         n_checks++; if (rdy_vec !== exp_rdy) begin n_fail++; $display("FAIL cont_rdy c=%0d got %b exp %b", c, rdy_vec, exp_rdy); end
         if (c >= 1) begin
            n_checks++; if (out_vld !== 1'b1 || out_src !== 2'(c - 1) || out_data !== base + 64'(c - 1)) begin
               n_fail++; $display("FAIL cont_head c=%0d got vld=%b src=%0d data=%h exp src=%0d", c, out_vld, out_src, out_data, c - 1);
            end
         end
         tick();
         if (c < 4) data_vld[c] = 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (accept_cnt[i] !== 32'd1) begin n_fail++; $display("FAIL cont_cnt[%0d] got %0d exp 1", i, accept_cnt[i]); end
      end
   endtask

   task automatic test_fairness();
      logic [3:0]  masks [3];
      int          exp_g [6];
      logic [31:0] exp_cnt [4];
      masks   = '{4'b1010, 4'b1010, 4'b1001};
      exp_g   = '{1, 3, 1, 3, 0, 3};
      exp_cnt = '{32'd2, 32'd3, 32'd1, 32'd4};
      out_rdy = 1'b1;
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 4; i++) data_vld[i] = masks[r][i];
         for (int s = 0; s < 2; s++) begin
            #1;
            n_checks++; if (rdy_vec !== (4'b0001 << exp_g[2*r+s])) begin
               n_fail++; $display("FAIL fair_rdy r=%0d s=%0d got %b exp cpu%0d", r, s, rdy_vec, exp_g[2*r+s]);
            end
            tick();
            data_vld[exp_g[2*r+s]] = 1'b0;
         end
      end
      #1;
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (accept_cnt[i] !== exp_cnt[i]) begin n_fail++; $display("FAIL fair_cnt[%0d] got %0d exp %0d", i, accept_cnt[i], exp_cnt[i]); end
      end
      tick();
   endtask

   task automatic test_backpressure();
      logic [63:0] base;
      int          gen [4];
      logic [3:0]  xfer;
      logic [3:0]  exp_rdy;
      int          exp_g [6];
      int          hsrc  [6];
      int          hgen  [6];
      base  = 64'hB000_0000_0000_0000;
      exp_g = '{-1, 0, 1, 2, 3, 0};
      hsrc  = '{0, 1, 2, 3, 0, 1};
      hgen  = '{0, 0, 0, 0, 1, 1};
      do_reset();
      out_rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         gen[i] = 0; data[i] = base | (64'(i) << 8); data_vld[i] = 1'b1;
      end
      for (int c = 0; c < 6; c++) begin
         #1;
         exp_rdy = (c < 4) ? (4'b0001 << c) : 4'b0000;
         n_checks++; if (rdy_vec !== exp_rdy) begin n_fail++; $display("FAIL bp_fill_rdy c=%0d got %b exp %b", c, rdy_vec, exp_rdy); end
         if (c >= 1) begin
            n_checks++; if (out_vld !== 1'b1 || out_src !== 2'd0) begin n_fail++; $display("FAIL bp_fill_head c=%0d got vld=%b src=%0d exp 1/0", c, out_vld, out_src); end
         end
         xfer = rdy_vec;
         tick();
         for (int i = 0; i < 4; i++) if (xfer[i]) begin gen[i]++; data[i] = base | (64'(i) << 8) | 64'(gen[i]); end
      end
      out_rdy = 1'b1;
      for (int p = 0; p < 6; p++) begin
         #1;
         exp_rdy = (exp_g[p] < 0) ? 4'b0000 : (4'b0001 << exp_g[p]);
         n_checks++; if (rdy_vec !== exp_rdy) begin n_fail++; $display("FAIL bp_drain_rdy p=%0d got %b exp %b", p, rdy_vec, exp_rdy); end
         n_checks++; if (out_vld !== 1'b1 || out_src !== 2'(hsrc[p]) || out_data !== (base | (64'(hsrc[p]) << 8) | 64'(hgen[p]))) begin
            n_fail++; $display("FAIL bp_drain_head p=%0d got vld=%b src=%0d data=%h exp src=%0d gen=%0d", p, out_vld, out_src, out_data, hsrc[p], hgen[p]);
         end
         xfer = rdy_vec;
         tick();
         for (int i = 0; i < 4; i++) if (xfer[i]) begin gen[i]++; data[i] = base | (64'(i) << 8) | 64'(gen[i]); end
      end
      for (int i = 0; i < 4; i++) data_vld[i] = 1'b0;
      repeat (5) tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      out_rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin data[i] = 64'hC0C0_0000_0000_0000 + 64'(i); data_vld[i] = 1'b1; end
      for (int c = 0; c < 3; c++) begin
         #1;
         n_checks++; if (rdy_vec !== (4'b0001 << c)) begin n_fail++; $display("FAIL mid_fill_rdy c=%0d got %b exp %b", c, rdy_vec, 4'b0001 << c); end
         tick();
         data_vld[c] = 1'b0;
      end
      #1;
      n_checks++; if (out_vld !== 1'b1 || out_src !== 2'd0) begin n_fail++; $display("FAIL mid_buffered got vld=%b src=%0d exp 1/0", out_vld, out_src); end
      data[1]     = 64'hD1D1_D1D1_D1D1_D1D1;
      data_vld[1] = 1'b1;
      rst_n       = 1'b0;
      #1;
      n_checks++; if (rdy_vec !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_rdy got %b exp 0000", rdy_vec); end
      tick();
      rst_n = 1'b1;
      #1;
      n_checks++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL mid_after_vld got %b exp 0", out_vld); end
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (accept_cnt[i] !== 32'd0) begin n_fail++; $display("FAIL mid_cnt[%0d] got %0d exp 0", i, accept_cnt[i]); end
      end
      n_checks++; if (rdy_vec !== 4'b0010) begin n_fail++; $display("FAIL mid_reaccept_rdy got %b exp 0010", rdy_vec); end
      out_rdy = 1'b1;
      tick();
      data_vld[1] = 1'b0;
      #1;
      n_checks++; if (out_vld !== 1'b1 || out_src !== 2'd1 || out_data !== 64'hD1D1_D1D1_D1D1_D1D1) begin
         n_fail++; $display("FAIL mid_new_head got vld=%b src=%0d data=%h exp 1/1/d1d1d1d1d1d1d1d1", out_vld, out_src, out_data);
      end
      n_checks++; if (accept_cnt[1] !== 32'd1) begin n_fail++; $display("FAIL mid_new_cnt1 got %0d exp 1", accept_cnt[1]); end
      tick();
      n_checks++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL mid_no_stale got vld=%b src=%0d exp 0", out_vld, out_src); end
   endtask

   initial begin
      rst_n   = 1'b0;
      out_rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin data_vld[i] = 1'b0; data[i] = '0; end
      test_reset();
      test_single();
      test_contention();
      test_fairness();
      test_backpressure();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
